// File: rtl/serial_adder_accum.sv
// Bit-serial add/subtract unit with a WIDTH-bit accumulator on an 8-bit io_in/io_out tile interface.
// Operands arrive LSB first; the result is shifted out one registered bit per cycle, with flags on completion.
module serial_adder_accum #(
    parameter int WIDTH = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic clk;
    logic rst_n;
    logic start;
    logic a_bit;
    logic b_bit;
    logic sub_in;
    logic acc_mode_in;
    logic unused_spare;

    assign clk          = io_in[0];
    assign rst_n        = io_in[1];
    assign start        = io_in[2];
    assign a_bit        = io_in[3];
    assign b_bit        = io_in[4];
    assign sub_in       = io_in[5];
    assign acc_mode_in  = io_in[6];
    assign unused_spare = io_in[7];

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_sreg;
    logic             sub_q;
    logic             acc_mode_q;
    logic             sum_bit;
    logic             sum_valid;
    logic             done;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             acc_msb;

    logic             accept;
    logic             consume;
    logic             last_bit;
    logic             op_sub;
    logic             op_acc;
    logic [CW-1:0]    bit_idx;
    logic             carry_in;
    logic             b_eff;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] result_next;

    // The start cycle consumes bit 0 directly from the pins, so the mode
    // controls and carry seed bypass their registers on that cycle.
    always_comb begin
        accept      = start && ((state == S_IDLE) || (state == S_DONE));
        consume     = accept || (state == S_RUN);
        last_bit    = (state == S_RUN) && (cnt == LAST_CNT);
        op_sub      = accept ? sub_in : sub_q;
        op_acc      = accept ? acc_mode_in : acc_mode_q;
        bit_idx     = accept ? '0 : cnt;
        carry_in    = accept ? sub_in : carry;
        b_eff       = (op_acc ? acc[bit_idx] : b_bit) ^ op_sub;
        s           = a_bit ^ b_eff ^ carry_in;
        c_next      = (a_bit & b_eff) | (a_bit & carry_in) | (b_eff & carry_in);
        result_next = {s, result_sreg[WIDTH-1:1]};
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            acc         <= '0;
            result_sreg <= '0;
            sub_q       <= 1'b0;
            acc_mode_q  <= 1'b0;
            sum_bit     <= 1'b0;
            sum_valid   <= 1'b0;
            done        <= 1'b0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            acc_msb     <= 1'b0;
        end else begin
            sum_valid <= consume;
            sum_bit   <= consume ? s : 1'b0;
            done      <= last_bit;
            acc_msb   <= acc[WIDTH-1];

            if (consume) begin
                result_sreg <= result_next;
                carry       <= c_next;
            end

            if (accept) begin
                state      <= S_RUN;
                cnt        <= ONE_CNT;
                sub_q      <= sub_in;
                acc_mode_q <= acc_mode_in;
                carry_out  <= 1'b0;
                overflow   <= 1'b0;
                zero       <= 1'b0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (last_bit) begin
                            // Flags and accumulator commit together with the last result bit.
                            state     <= S_DONE;
                            cnt       <= '0;
                            carry_out <= c_next;
                            overflow  <= carry ^ c_next;
                            zero      <= (result_next == '0);
                            acc       <= result_next;
                        end else begin
                            cnt <= cnt + ONE_CNT;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign io_out = {zero, acc_msb, (state == S_RUN), overflow, carry_out, done, sum_valid, sum_bit};

endmodule
